// File: rtl/cordic_issue_ctrl.sv
// Bus-side issue controller for the CORDIC custom-instruction unit: register file, issue FSM, timeout, pending slot.
// Optional completion interrupt enabled by defining CORDIC_IRQ_EN.
module cordic_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic        data_write,
  input  logic        data_read,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic [31:0] ci_dataa,
  output logic        ci_start,
  output logic        ci_cos,
  output logic        ci_clk_en,
  output logic        ci_reset,
  input  logic        ci_done,
  input  logic [31:0] ci_result,
  output logic        user_interrupt
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] ADDR_ARG_SIN = AW'(8'h00);
  localparam logic [AW-1:0] ADDR_ARG_COS = AW'(8'h04);
  localparam logic [AW-1:0] ADDR_RESULT  = AW'(8'h08);
  localparam logic [AW-1:0] ADDR_STATUS  = AW'(8'h0C);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             pend_valid, pend_cos;
  logic [DW-1:0]    pend_op;
  logic [DW-1:0]    result;
  logic             valid, timeout, overrun;
  logic             abort_q, rd_stall;
  logic             issue_c, done_hit_c, abort_hit_c;
  logic             busy_c, arg_wr_c, wr_cos_c;
  logic [DW-1:0]    rd_mux_c;

  assign busy_c   = (state_q != S_IDLE);
  assign arg_wr_c = data_write && ((address == ADDR_ARG_SIN) || (address == ADDR_ARG_COS));
  assign wr_cos_c = (address == ADDR_ARG_COS);

  assign ci_clk_en = rst_n;
  assign ci_reset  = ~rst_n | abort_q;

  always_comb begin
    rd_mux_c = '0;
    if (address == ADDR_RESULT)      rd_mux_c = result;
    else if (address == ADDR_STATUS) rd_mux_c = {27'd0, overrun, timeout, pend_valid, valid, busy_c};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d     = state_q;
    issue_c     = 1'b0;
    done_hit_c  = 1'b0;
    abort_hit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_valid || arg_wr_c) begin
          issue_c = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (ci_done) begin
          done_hit_c = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort_hit_c = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, pending slot, status flags and read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ci_start   <= 1'b0;
      ci_dataa   <= '0;
      ci_cos     <= 1'b0;
      abort_q    <= 1'b0;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_cos   <= 1'b0;
      pend_op    <= '0;
      result     <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
      rd_stall   <= 1'b0;
      data_ready <= 1'b0;
      data_out   <= '0;
    end else begin
      ci_start   <= issue_c;
      abort_q    <= abort_hit_c;
      data_ready <= 1'b0;
      data_out   <= '0;

      if (issue_c) begin
        ci_dataa <= pend_valid ? pend_op : data_in;
        ci_cos   <= pend_valid ? pend_cos : wr_cos_c;
        valid    <= 1'b0;
      end

      if (state_q == S_ISSUE)     cnt <= '0;
      else if (state_q == S_WAIT) cnt <= cnt + CNT_W'(1);

      // Slot refills in the same cycle it is drained, so an idle-time write never collides
      if (arg_wr_c && (busy_c || pend_valid)) begin
        if (busy_c && pend_valid) begin
          overrun <= 1'b1;
        end else begin
          pend_op    <= data_in;
          pend_cos   <= wr_cos_c;
          pend_valid <= 1'b1;
        end
      end else if (issue_c && pend_valid) begin
        pend_valid <= 1'b0;
      end

      if (data_write && (address == ADDR_STATUS)) begin
        if (data_in[3]) timeout <= 1'b0;
        if (data_in[4] && !(arg_wr_c && busy_c && pend_valid)) overrun <= 1'b0;
      end

      if (done_hit_c) begin
        result <= ci_result;
        valid  <= 1'b1;
      end
      if (abort_hit_c) begin
        timeout <= 1'b1;
        valid   <= 1'b0;
      end

      // A RESULT read while busy parks until the unit completes or the abort pulse has gone out
      if (rd_stall) begin
        if (done_hit_c) begin
          data_ready <= 1'b1;
          data_out   <= ci_result;
          rd_stall   <= 1'b0;
        end else if (abort_q) begin
          data_ready <= 1'b1;
          data_out   <= result;
          rd_stall   <= 1'b0;
        end
      end else if (data_read) begin
        if ((address == ADDR_RESULT) && busy_c) begin
          if (done_hit_c) begin
            data_ready <= 1'b1;
            data_out   <= ci_result;
          end else begin
            rd_stall <= 1'b1;
          end
        end else begin
          data_ready <= 1'b1;
          data_out   <= rd_mux_c;
        end
      end
    end
  end

`ifdef CORDIC_IRQ_EN
  logic irq;

  // Completion interrupt: set wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      if ((data_read && !rd_stall && (address == ADDR_RESULT)) ||
          (data_write && (address == ADDR_STATUS) && data_in[1]))
        irq <= 1'b0;
      if (done_hit_c || abort_hit_c) irq <= 1'b1;
    end
  end

  assign user_interrupt = irq;
`else
  assign user_interrupt = 1'b0;
`endif

endmodule
